dm_controller: RTL and testbench
================================

# dm_controller

Shared data-memory controller on the downstream side of the processor cores. It owns the data-memory array and gives every core a registered read port. It serialises simultaneous core writes through a round-robin arbiter and drives each core's 2-bit `status` input. It also runs the global run/done state machine, raising DONE once every core has asserted `end_process`.

## Interface
- `NUM_CORES`, default 4: number of processor cores attached; must be at least 2.
- `DATA_W`, default 16: data word width; matches the core bus.
- `ADDR_W`, default 16: core address width (`AR_out`).
- `DEPTH`, default 256: number of memory words; must be a power of two.
- `CNT_W`, default 32: width of the run-cycle counter.

Ports:
- `clk`  in  1: single clock, rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `start`  in  1: one-cycle pulse that starts or restarts a run.
- `AR_in`  in  NUM_CORES*ADDR_W: per-core address; core i occupies slice [i*ADDR_W +: ADDR_W].
- `bus_in`  in  NUM_CORES*DATA_W: per-core write data (the core bus).
- `DM_write_en`  in  NUM_CORES: per-core write request.
- `end_process`  in  NUM_CORES: per-core completion flag.
- `DM_out`  out  NUM_CORES*DATA_W: per-core registered read data.
- `status`  out  NUM_CORES*2: per-core status code.
- `run_cycles`  out  CNT_W: number of cycles spent in RUN during the last or current run.
- `done`  out  1: high while the FSM is in DONE.

## Operation
- Status codes: IDLE=2'b00, RUN=2'b01, WAIT=2'b10, DONE=2'b11.
- FSM states and transitions:
  - IDLE, on `start`, goes to RUN.
  - RUN goes to DONE when the sticky per-core done flags are all set.
  - DONE, on `start`, goes to RUN.
- Done flags:
  - Each flag is set by `end_process[i]` while the FSM is in RUN.
  - All flags are cleared on every entry to RUN.
- Status per core:
  - In IDLE and DONE, every core's status equals the FSM code.
  - In RUN, a core's status is WAIT, combinationally, when `DM_write_en[i]` is high and core i does not hold the grant; otherwise it is RUN.
- Write arbitration:
  - Writes are accepted only in RUN. Requests in IDLE or DONE are ignored, and status does not show WAIT.
  - At most one write commits per cycle: `mem[AR_in[i][log2(DEPTH)-1:0]] <= bus_in[i]`.
  - Grant goes round-robin starting at `ptr`. After a grant, `ptr` moves to (granted+1) mod NUM_CORES. With no requests, `ptr` holds.
  - A core seeing WAIT must hold its request, address and data stable until WAIT drops. Its write commits on the edge that ends its first cycle with status RUN and request high.
- Reads:
  - Every cycle, in all states, `DM_out[i] <= mem[AR_in[i] index]`.
  - A same-cycle write to the same address returns the old data; the new data is visible on the next read.
- Addressing: upper address bits above log2(DEPTH) are ignored (the address wraps).
- `run_cycles`:
  - Cleared to 0 on entry to RUN.
  - Increments each cycle in RUN and saturates at all-ones.
  - Holds its value in DONE and IDLE.

## Timing
- Reset values:
  - FSM = IDLE, `ptr` = 0, done flags = 0.
  - `DM_out` = 0, `run_cycles` = 0, `done` = 0.
  - Every `status` = IDLE.
  - The memory array is not reset.
- Read latency is 1 cycle: the address presented in cycle t appears on `DM_out` after edge t.
- Write latency:
  - The granted write commits at the end of the request cycle.
  - Worst-case wait is NUM_CORES-1 cycles with every core requesting continuously.
- `start` in cycle t: `status` = RUN from cycle t+1; `run_cycles` = 1 after edge t+1.
- The last `end_process` in cycle t: `done` and status DONE from cycle t+1. The write in cycle t still commits if granted.
- `start` while already in RUN is ignored.
- Reset asserted mid-run forces the reset values immediately. Any ungranted write is dropped.

## Structure
- Shared package `dm_pkg` holds:
  - status code localparams (IDLE, RUN, WAIT, DONE);
  - the FSM state enum;
  - a `clog2` helper if one is not already shared.
- Sub-module `rr_arbiter` takes parameter `N`. Its inputs are `clk`, `rst_n`, `req[N]` and `en`. It outputs a one-hot `grant[N]` and owns `ptr`.
- The memory array and the per-core read registers stay inline in `dm_controller`.

## Test plan
- Reset, then `start`:
  - Status is 00 for all cores during reset and 01 on the cycle after `start`.
  - `run_cycles` counts 1, 2, 3, … from the cycle after `start`.
- Core 0 writes 16'hBEEF to address 5; core 1 reads address 5 in the next cycle: `DM_out[1]` = 16'hBEEF one cycle after that read.
- With `ptr` = 0, cores 0 and 2 request in the same cycle:
  - Core 0 commits first and core 2 shows WAIT for 1 cycle, then commits.
  - Next `ptr` = 3.
- All 4 cores request continuously: grants go 0,1,2,3 and each core sees exactly 3 WAIT cycles.
- Address 16'h0105 with DEPTH=256: the write lands in word 5.
- End of run:
  - `end_process` rises on cores 3,1,0,2 in separate cycles.
  - `done` rises the cycle after core 2's flag, and `run_cycles` then freezes.
  - A following `start` clears the done flags and `run_cycles`.

Source files
------------

// File: rtl/dm_pkg.sv
// Shared definitions for the data-memory controller: status codes, FSM
// state encoding and a constant-width helper.
package dm_pkg;

  localparam logic [1:0] IDLE = 2'b00;
  localparam logic [1:0] RUN  = 2'b01;
  localparam logic [1:0] WAIT = 2'b10;
  localparam logic [1:0] DONE = 2'b11;

  // State encodings equal the status codes shown to the cores.
  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_DONE = 2'b11
  } state_t;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/dm_if.sv
// Core-side bundle of the data-memory controller. master = the cores/bench,
// slave = the controller. Writes use a request/wait scheme: a core holds
// DM_write_en, address and data stable while its status reads WAIT; the
// write commits on the edge ending its first cycle with status RUN.
interface dm_if
  import dm_pkg::*;
#(
  parameter int NUM_CORES = 4,
  parameter int DATA_W    = 16,
  parameter int ADDR_W    = 16,
  parameter int CNT_W     = 32
) ();

  localparam int PW = clog2(NUM_CORES);

  logic                        start;
  logic [NUM_CORES*ADDR_W-1:0] AR_in;
  logic [NUM_CORES*DATA_W-1:0] bus_in;
  logic [NUM_CORES-1:0]        DM_write_en;
  logic [NUM_CORES-1:0]        end_process;
  logic [NUM_CORES*DATA_W-1:0] DM_out;
  logic [NUM_CORES*2-1:0]      status;
  logic [CNT_W-1:0]            run_cycles;
  logic                        done;
  logic [1:0]                  fsm_state;
  logic [PW-1:0]               ptr;

  modport master (
    output start, AR_in, bus_in, DM_write_en, end_process,
    input  DM_out, status, run_cycles, done, fsm_state, ptr
  );

  modport slave (
    input  start, AR_in, bus_in, DM_write_en, end_process,
    output DM_out, status, run_cycles, done, fsm_state, ptr
  );

endinterface

// File: rtl/dm_controller_rr_arbiter.sv
// Round-robin write arbiter: one-hot grant searched upward from ptr,
// ptr advances past the winner and holds when nothing is granted.
module rr_arbiter
  import dm_pkg::*;
#(
  parameter int N = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [N-1:0]        req,
  input  logic                en,
  output logic [N-1:0]        grant,
  output logic [clog2(N)-1:0] ptr
);

  localparam int PW = clog2(N);

  logic [PW-1:0] gidx;
  logic          hit;
  int            idx;

  always_comb begin
    grant = '0;
    gidx  = '0;
    hit   = 1'b0;
    idx   = 0;
    for (int k = 0; k < N; k++) begin
      idx = int'(ptr) + k;
      if (idx >= N) idx = idx - N;
      if (en && !hit && req[idx]) begin
        grant[idx] = 1'b1;
        gidx       = PW'(idx);
        hit        = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (hit) begin
      ptr <= (gidx == PW'(N - 1)) ? '0 : gidx + 1'b1;
    end
  end

endmodule

// File: rtl/dm_controller.sv
// Shared data-memory controller: per-core registered read ports, one
// arbitrated write per cycle, and the global IDLE/RUN/DONE run tracker.
module dm_controller
  import dm_pkg::*;
#(
  parameter int NUM_CORES = 4,
  parameter int DATA_W    = 16,
  parameter int ADDR_W    = 16,
  parameter int DEPTH     = 256,
  parameter int CNT_W     = 32
) (
  input  logic clk,
  input  logic rst_n,
  dm_if.slave  bus
);

  localparam int AW = clog2(DEPTH);
  localparam int PW = clog2(NUM_CORES);

  state_t                      state;
  logic [NUM_CORES-1:0]        flags;
  logic [NUM_CORES-1:0]        all_done;
  logic [NUM_CORES-1:0]        grant;
  logic [PW-1:0]               ptr;
  logic [CNT_W-1:0]            run_cnt;
  logic                        run_en;
  logic [DATA_W-1:0]           mem [DEPTH];
  logic [NUM_CORES*DATA_W-1:0] rd_q;
  logic [NUM_CORES*2-1:0]      st;
  logic                        wr_hit;
  logic [AW-1:0]               wr_addr;
  logic [DATA_W-1:0]           wr_data;

  assign run_en   = (state == S_RUN);
  assign all_done = flags | bus.end_process;

  rr_arbiter #(.N(NUM_CORES)) u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (bus.DM_write_en),
    .en    (run_en),
    .grant (grant),
    .ptr   (ptr)
  );

  // Flags and counter are cleared on the start edge so the first RUN
  // cycle is counted as 1 and stale end_process flags cannot end the run.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      flags   <= '0;
      run_cnt <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (bus.start) begin
            state   <= S_RUN;
            flags   <= '0;
            run_cnt <= '0;
          end
        end
        S_RUN: begin
          flags <= all_done;
          if (run_cnt != '1) run_cnt <= run_cnt + 1'b1;
          if (&all_done) state <= S_DONE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    wr_hit  = 1'b0;
    wr_addr = '0;
    wr_data = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      if (grant[i]) begin
        wr_hit  = 1'b1;
        wr_addr = bus.AR_in[i*ADDR_W +: AW];
        wr_data = bus.bus_in[i*DATA_W +: DATA_W];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_hit) mem[wr_addr] <= wr_data;
  end

  // Reads sample mem before this edge's write lands: same-cycle hits see old data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_q <= '0;
    end else begin
      for (int i = 0; i < NUM_CORES; i++) begin
        rd_q[i*DATA_W +: DATA_W] <= mem[bus.AR_in[i*ADDR_W +: AW]];
      end
    end
  end

  always_comb begin
    st = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      if (run_en) st[i*2 +: 2] = (bus.DM_write_en[i] && !grant[i]) ? WAIT : RUN;
      else        st[i*2 +: 2] = state;
    end
  end

  assign bus.DM_out     = rd_q;
  assign bus.status     = st;
  assign bus.run_cycles = run_cnt;
  assign bus.done       = (state == S_DONE);
  assign bus.fsm_state  = state;
  assign bus.ptr        = ptr;

endmodule

// File: tb/tb_dm_controller.sv
// Directed bench for dm_controller with hand-computed expected values.
module tb_dm_controller;

  localparam int NC = 4;
  localparam int DW = 16;
  localparam int AWD = 16;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;
  int   exp_rc;
  bit   in_run;
  int   wc [NC];
  logic [7:0] exp_st;

  dm_if #(.NUM_CORES(NC), .DATA_W(DW), .ADDR_W(AWD), .CNT_W(32)) bus ();

  dm_controller #(.NUM_CORES(NC), .DATA_W(DW), .ADDR_W(AWD), .DEPTH(256), .CNT_W(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    if (in_run) exp_rc++;
    #1;
  endtask

  task automatic set_core(input int i, input logic [15:0] a, input logic [15:0] d);
    bus.AR_in[i*AWD +: AWD] = a;
    bus.bus_in[i*DW +: DW]  = d;
  endtask

  function automatic logic [15:0] dm(input int i);
    return bus.DM_out[i*DW +: DW];
  endfunction

  initial begin
    total = 0; bad = 0; exp_rc = 0; in_run = 1'b0;
    rst_n = 1'b0;
    bus.start = 1'b0; bus.AR_in = '0; bus.bus_in = '0;
    bus.DM_write_en = '0; bus.end_process = '0;
    foreach (wc[i]) wc[i] = 0;
    step(); step();
    chk("rst_status", bus.status, 8'h00);
    chk("rst_done", bus.done, 1'b0);
    chk("rst_rc", bus.run_cycles, 0);
    chk("rst_dm", bus.DM_out, 64'h0);
    chk("rst_ptr", bus.ptr, 0);
    rst_n = 1'b1;
    step();

    // start pulse
    bus.start = 1'b1;
    #1 chk("idle_status", bus.status, 8'h00);
    step();
    bus.start = 1'b0; in_run = 1'b1;
    chk("run_status", bus.status, 8'h55);
    chk("rc0", bus.run_cycles, 0);
    step(); chk("rc1", bus.run_cycles, 1);
    step(); chk("rc2", bus.run_cycles, 2);
    step(); chk("rc3", bus.run_cycles, 3);

    // all four cores requesting continuously from ptr=0
    chk("ptr_pre4", bus.ptr, 0);
    for (int i = 0; i < NC; i++) set_core(i, 16'h0010 + 16'(i), 16'hA000 + 16'(i));
    bus.DM_write_en = 4'hF;
    for (int k = 0; k < NC; k++) begin
      #1;
      for (int i = 0; i < NC; i++) begin
        exp_st[i*2 +: 2] = (i == k) ? 2'b01 : 2'b10;
        if (bus.status[i*2 +: 2] == 2'b10) wc[i]++;
      end
      chk($sformatf("all4_status_%0d", k), bus.status, exp_st);
      step();
      chk($sformatf("all4_ptr_%0d", k), bus.ptr, (k + 1) % NC);
    end
    bus.DM_write_en = 4'h0;
    for (int i = 0; i < NC; i++) chk($sformatf("wait_cnt_%0d", i), wc[i], 3);
    step();
    for (int i = 0; i < NC; i++) chk($sformatf("all4_rd_%0d", i), dm(i), 16'hA000 + 16'(i));

    // cores 0 and 2 collide with ptr=0
    set_core(0, 16'h0005, 16'hBEEF);
    set_core(2, 16'h0107, 16'h2222);
    bus.DM_write_en = 4'b0101;
    #1 chk("col_status1", bus.status, 8'h65);
    step();
    chk("col_ptr1", bus.ptr, 1);
    bus.DM_write_en = 4'b0100;
    #1 chk("col_status2", bus.status, 8'h55);
    step();
    chk("col_ptr2", bus.ptr, 3);
    bus.DM_write_en = 4'b0000;
    set_core(1, 16'h0005, 16'h0000);
    step();
    step();
    chk("rd_beef", dm(1), 16'hBEEF);

    // wrapped address write by core 3; core 1 reads the same word that cycle
    set_core(3, 16'h0105, 16'h1234);
    bus.DM_write_en = 4'b1000;
    #1 chk("wrap_status", bus.status, 8'h55);
    step();
    chk("same_cycle_old", dm(1), 16'hBEEF);
    bus.DM_write_en = 4'b0000;
    set_core(0, 16'h0005, 16'h0000);
    set_core(2, 16'h0007, 16'h0000);
    step();
    chk("wrap_rd5", dm(0), 16'h1234);
    chk("wrap_rd7", dm(2), 16'h2222);
    chk("wrap_ptr", bus.ptr, 0);
    chk("rc_mid", bus.run_cycles, exp_rc);

    // end of run: cores 3,1,0,2; last cycle also carries a granted write
    bus.end_process = 4'b1000; step();
    bus.end_process = 4'b0010; step();
    bus.end_process = 4'b0001; step();
    chk("done_early", bus.done, 1'b0);
    bus.end_process = 4'b0100;
    set_core(1, 16'h0008, 16'h5A5A);
    bus.DM_write_en = 4'b0010;
    step();
    in_run = 1'b0;
    bus.end_process = 4'b0000;
    bus.DM_write_en = 4'b0000;
    chk("done_rise", bus.done, 1'b1);
    chk("done_status", bus.status, 8'hFF);
    chk("done_state", bus.fsm_state, 2'b11);

    // writes in DONE are ignored and never show WAIT
    set_core(0, 16'h0005, 16'hDEAD);
    set_core(1, 16'h0005, 16'hDEAD);
    bus.DM_write_en = 4'b0011;
    #1 chk("done_nowait", bus.status, 8'hFF);
    step();
    bus.DM_write_en = 4'b0000;
    set_core(1, 16'h0008, 16'h0000);
    step(); step();
    chk("done_ignored", dm(0), 16'h1234);
    chk("last_write", dm(1), 16'h5A5A);
    chk("rc_frozen", bus.run_cycles, exp_rc);

    // restart clears flags and counter
    bus.start = 1'b1;
    step();
    bus.start = 1'b0; in_run = 1'b1; exp_rc = 0;
    chk("re_status", bus.status, 8'h55);
    chk("re_done", bus.done, 1'b0);
    chk("re_rc0", bus.run_cycles, 0);
    bus.end_process = 4'b0001;
    step();
    bus.end_process = 4'b0000;
    chk("re_rc1", bus.run_cycles, 1);
    chk("flags_cleared", bus.done, 1'b0);
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    step();
    chk("start_in_run", bus.run_cycles, exp_rc);

    // asynchronous reset mid-run
    rst_n = 1'b0;
    #1;
    chk("mid_rst_status", bus.status, 8'h00);
    chk("mid_rst_rc", bus.run_cycles, 0);
    chk("mid_rst_dm", bus.DM_out, 64'h0);
    chk("mid_rst_state", bus.fsm_state, 2'b00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
